// File: rtl/serial_addsub_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// serial_addsub_ctrl_pkg
//   Shared definitions for the bit-serial add/subtract engine:
//   FSM state encodings, operation codes and the round-robin pick helper.
// ---------------------------------------------------------------------------
package serial_addsub_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Returns the id of the requester to serve. With both requesting, the
    // one that was not served last wins, so neither side can starve.
    function automatic logic pick_requester(
        input logic r0,
        input logic r1,
        input logic last_served
    );
        logic id;
        if (r0 && r1) begin
            id = ~last_served;
        end else begin
            id = r1;
        end
        return id;
    endfunction

endpackage

// File: rtl/full_adder_substractor.sv
// ---------------------------------------------------------------------------
// full_adder_substractor
//   1-bit full adder / subtractor cell. With sel=1 the b input is inverted,
//   so a two's-complement subtract is obtained by also seeding cin=1 on the
//   LSB.
//   Ports:
//     a, b   operand bits
//     cin    carry in
//     sel    0 = add, 1 = subtract (inverts b)
//     sum    sum bit
//     cout   carry out
// ---------------------------------------------------------------------------
module full_adder_substractor (
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic sel,
    output logic sum,
    output logic cout
);

    logic b_eff;

    assign b_eff = b ^ sel;
    assign sum   = a ^ b_eff ^ cin;
    assign cout  = (a & b_eff) | (cin & (a ^ b_eff));

endmodule

// File: rtl/serial_addsub_ctrl.sv
// ---------------------------------------------------------------------------
// serial_addsub_ctrl
//   Bit-serial add/subtract engine shared by two requesters. One 1-bit
//   full_adder_substractor cell is sequenced LSB-first over WIDTH cycles,
//   the carry living in a flop between steps. Round-robin arbitration picks
//   the requester when both ask at once.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting; requests are sampled only here
//   SHIFT  | one operand bit per cycle through the cell, LSB first
//   DONE   | result valid, one-cycle done pulse to the granted requester
//
//   Ports:
//     clk, rst_n            clock (rising edge), async active-low reset
//     req0/op0/a0/b0        requester 0 request, op (0=add,1=sub), operands
//     req1/op1/a1/b1        requester 1 request, op, operands
//     busy                  engine occupied (SHIFT or DONE)
//     grant                 id of requester being served / last served
//     done0, done1          one-cycle completion pulses
//     result                WIDTH-bit sum/difference, held until next grant
//     carry_out             final carry (subtract: 1 = no borrow)
//     overflow              two's-complement overflow
// ---------------------------------------------------------------------------
module serial_addsub_ctrl
    import serial_addsub_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             op0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic             op1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             busy,
    output logic             grant,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] MSB_STEP = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_sr_q, res_sr_d;
    logic             op_q, op_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             grant_q, grant_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;
    logic             done0_q, done0_d;
    logic             done1_q, done1_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_out_q, carry_out_d;
    logic             overflow_q, overflow_d;

    logic             sel_id;
    logic             sel_op;
    logic             fa_sum;
    logic             fa_cout;

    full_adder_substractor u_fas (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .cin  (carry_q),
        .sel  (op_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_comb begin
        state_d     = state_q;
        a_sr_d      = a_sr_q;
        b_sr_d      = b_sr_q;
        res_sr_d    = res_sr_q;
        op_d        = op_q;
        carry_d     = carry_q;
        count_d     = count_q;
        grant_d     = grant_q;
        last_d      = last_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;

        sel_id = pick_requester(req0, req1, last_q);
        sel_op = sel_id ? op1 : op0;

        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    grant_d     = sel_id;
                    last_d      = sel_id;
                    a_sr_d      = sel_id ? a1 : a0;
                    b_sr_d      = sel_id ? b1 : b0;
                    op_d        = sel_op;
                    // Subtract is a + ~b + 1: the +1 enters as the LSB carry.
                    carry_d     = (sel_op == OP_SUB);
                    count_d     = '0;
                    res_sr_d    = '0;
                    result_d    = '0;
                    carry_out_d = 1'b0;
                    overflow_d  = 1'b0;
                    state_d     = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                res_sr_d = {fa_sum, res_sr_q[WIDTH-1:1]};
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                carry_d  = fa_cout;
                count_d  = count_q + CNT_W'(1);
                if (count_q == MSB_STEP) begin
                    // carry_q here is the carry into the MSB.
                    overflow_d  = carry_q ^ fa_cout;
                    carry_out_d = fa_cout;
                    result_d    = {fa_sum, res_sr_q[WIDTH-1:1]};
                    state_d     = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status outputs are registered, so they are derived from the next
        // state; DONE only ever lasts one cycle, giving a one-cycle pulse.
        busy_d  = (state_d != ST_IDLE);
        done0_d = (state_d == ST_DONE) && !grant_d;
        done1_d = (state_d == ST_DONE) &&  grant_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_sr_q      <= '0;
            b_sr_q      <= '0;
            res_sr_q    <= '0;
            op_q        <= 1'b0;
            carry_q     <= 1'b0;
            count_q     <= '0;
            grant_q     <= 1'b0;
            last_q      <= 1'b1;
            busy_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sr_q      <= a_sr_d;
            b_sr_q      <= b_sr_d;
            res_sr_q    <= res_sr_d;
            op_q        <= op_d;
            carry_q     <= carry_d;
            count_q     <= count_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
        end
    end

    assign busy      = busy_q;
    assign grant     = grant_q;
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_addsub_ctrl
//   Directed bench for serial_addsub_ctrl (WIDTH=8). Inputs are driven and
//   outputs sampled on the falling edge; the DUT acts on the rising edge.
// ---------------------------------------------------------------------------
module tb_serial_addsub_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             req0, op0, req1, op1;
    logic [WIDTH-1:0] a0, b0, a1, b1;
    logic             busy, grant, done0, done1;
    logic [WIDTH-1:0] result;
    logic             carry_out, overflow;

    int n_checks = 0;
    int n_pass   = 0;

    serial_addsub_ctrl #(.WIDTH(WIDTH), .CNT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .op0       (op0),
        .a0        (a0),
        .b0        (b0),
        .req1      (req1),
        .op1       (op1),
        .a1        (a1),
        .b1        (b1),
        .busy      (busy),
        .grant     (grant),
        .done0     (done0),
        .done1     (done1),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advances whole cycles until the chosen done pulse is seen (bounded).
    task automatic wait_done(input logic id, output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end while (((id ? done1 : done0) == 1'b0) && cyc < 30);
    endtask

    // Issues one request from IDLE (called on a falling edge) and checks the
    // completion. done is expected on the falling edge after the 9th rising
    // edge: the sampling edge plus WIDTH shift edges.
    task automatic run_op(input string tag, input logic id, input logic op,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] exp_r, input logic exp_c,
                          input logic exp_v);
        int cyc;
        if (id) begin
            req1 = 1'b1; op1 = op; a1 = a; b1 = b;
        end else begin
            req0 = 1'b1; op0 = op; a0 = a; b0 = b;
        end
        wait_done(id, cyc);
        check_val({tag, "_lat"},   cyc, WIDTH + 1);
        check_val({tag, "_res"},   result, exp_r);
        check_val({tag, "_cout"},  carry_out, exp_c);
        check_val({tag, "_ovf"},   overflow, exp_v);
        check_val({tag, "_grant"}, grant, id);
        check_val({tag, "_busy"},  busy, 1'b1);
        req0 = 1'b0;
        req1 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_val({tag, "_pulse"}, {done1, done0}, 2'b00);
        check_val({tag, "_idle"},  busy, 1'b0);
    endtask

    initial begin
        int cyc;
        int n_done;
        int last_done_cyc;
        logic prev_done;
        logic any_done;
        logic exp_id [4];
        logic [WIDTH-1:0] exp_res [4];

        rst_n = 1'b0;
        req0 = 1'b0; op0 = 1'b0; a0 = '0; b0 = '0;
        req1 = 1'b0; op1 = 1'b0; a1 = '0; b1 = '0;
        repeat (2) @(negedge clk);

        check_val("rst_busy",  busy, 1'b0);
        check_val("rst_done",  {done1, done0}, 2'b00);
        check_val("rst_res",   result, 8'h00);
        check_val("rst_flags", {carry_out, overflow}, 2'b00);
        check_val("rst_grant", grant, 1'b0);

        rst_n = 1'b1;
        @(negedge clk);

        run_op("add",     1'b0, 1'b0, 8'h35, 8'h1A, 8'h4F, 1'b0, 1'b0);
        run_op("sub",     1'b1, 1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0);
        run_op("ovf_add", 1'b0, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
        run_op("ovf_sub", 1'b1, 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);

        // Arbitration: both requests held from reset, expect 0,1,0,1.
        rst_n = 1'b0;
        req0 = 1'b1; op0 = 1'b0; a0 = 8'h03; b0 = 8'h04;
        req1 = 1'b1; op1 = 1'b1; a1 = 8'h20; b1 = 8'h05;
        exp_id  = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_res = '{8'h07, 8'h1B, 8'h07, 8'h1B};
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        prev_done = 1'b0;
        last_done_cyc = 0;
        for (int c = 1; c <= 60 && n_done < 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (prev_done) begin
                check_val("arb_pulse_w", {done1, done0}, 2'b00);
                check_val("arb_gap_idle", busy, 1'b0);
            end
            prev_done = done0 | done1;
            if (done0 | done1) begin
                check_val("arb_order", {done1, done0}, exp_id[n_done] ? 2'b10 : 2'b01);
                check_val("arb_res", result, exp_res[n_done]);
                // First done on the 9th cycle, then one every WIDTH+2 cycles.
                check_val("arb_timing", c, 9 + 10 * n_done);
                last_done_cyc = c;
                n_done++;
                if (n_done == 4) begin
                    req0 = 1'b0;
                    req1 = 1'b0;
                end
            end
        end
        check_val("arb_count", n_done, 4);
        @(posedge clk);
        @(negedge clk);
        check_val("arb_end_pulse", {done1, done0}, 2'b00);
        check_val("arb_end_idle", busy, 1'b0);

        // Contention: requester 1 arrives while requester 0 is shifting.
        req0 = 1'b1; op0 = 1'b0; a0 = 8'h11; b0 = 8'h22;
        @(posedge clk);
        @(negedge clk);
        check_val("cont_grant0", grant, 1'b0);
        check_val("cont_busy", busy, 1'b1);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        req1 = 1'b1; op1 = 1'b0; a1 = 8'h40; b1 = 8'h05;
        a0 = 8'hFF; b0 = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        check_val("cont_hold_grant", grant, 1'b0);
        wait_done(1'b0, cyc);
        check_val("cont_lat0", cyc, 5);
        check_val("cont_res0", result, 8'h33);
        check_val("cont_grant_d0", grant, 1'b0);
        req0 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_val("cont_idle", busy, 1'b0);
        check_val("cont_grant_idle", grant, 1'b0);
        wait_done(1'b1, cyc);
        check_val("cont_lat1", cyc, 9);
        check_val("cont_res1", result, 8'h45);
        check_val("cont_grant1", grant, 1'b1);
        req1 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_val("cont_pulse1", done1, 1'b0);

        // Reset in the middle of an operation (count == 3).
        req0 = 1'b1; op0 = 1'b0; a0 = 8'h55; b0 = 8'h11;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        check_val("mid_busy_pre", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_val("mid_busy", busy, 1'b0);
        check_val("mid_res", result, 8'h00);
        check_val("mid_done", {done1, done0}, 2'b00);
        req0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        any_done = 1'b0;
        repeat (12) begin
            @(posedge clk);
            @(negedge clk);
            any_done = any_done | done0 | done1;
        end
        check_val("mid_no_done", any_done, 1'b0);
        run_op("post_rst", 1'b0, 1'b0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_addsub_ctrl.md
Name: serial_addsub_ctrl

Overview:
- Bit-serial add/subtract engine and arbiter.
- Time-shares one instance of the team's 1-bit `full_adder_substractor` cell between two requesters, such as the cruise-control speed-increment and speed-decrement paths.
- Sequences the cell LSB-first over WIDTH cycles, holding the carry in a flop, and returns a WIDTH-bit result with carry and signed-overflow flags.
- Round-robin arbitration between the two requesters.

Parameters:
- WIDTH, 8, operand/result width in bits (legal 2..32).
- CNT_W, 5, bit-counter width; must satisfy 2^CNT_W >= WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req0  input  1  requester 0 operation request; held until done0.
- op0  input  1  requester 0 operation, 0=add (a+b), 1=subtract (a-b).
- a0  input  WIDTH  requester 0 operand A.
- b0  input  WIDTH  requester 0 operand B.
- req1  input  1  requester 1 request.
- op1  input  1  requester 1 operation.
- a1  input  WIDTH  requester 1 operand A.
- b1  input  WIDTH  requester 1 operand B.
- busy  output  1  engine occupied (SHIFT or DONE).
- grant  output  1  id of requester being served / last served.
- done0  output  1  one-cycle completion pulse for requester 0.
- done1  output  1  one-cycle completion pulse for requester 1.
- result  output  WIDTH  sum/difference; held until next grant.
- carry_out  output  1  final carry; for subtract, 1 means no borrow.
- overflow  output  1  two's-complement overflow.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy, done0, done1, result, carry_out, overflow = 0.
  - grant=0; internal last-served flop=1, so requester 0 wins first.
  - Reset mid-operation aborts it; no done pulse is issued and the operation must be re-requested.
- States: IDLE, SHIFT, DONE; all outputs registered.
- IDLE:
  - req sampled only here.
  - Single request is granted.
  - Both requests: grant = ~last_served.
  - On grant: latch a, b, op into shift registers; carry flop <= op; count <= 0; grant/last_served <= id; result, carry_out, overflow cleared; go to SHIFT.
  - No request: stay in IDLE.
- SHIFT:
  - Cell inputs: a=a_sr[0], b=b_sr[0], cin=carry flop, sel=op.
  - Each edge: result_sr <= {sum, result_sr[WIDTH-1:1]}; a_sr, b_sr shift right; carry <= cout; count++.
  - At count==WIDTH-1 (MSB step):
    - overflow <= carry flop XOR cout, i.e. carry into MSB XOR carry out of MSB.
    - carry_out <= cout.
    - go to DONE.
- DONE:
  - done0/done1 = 1 for exactly one cycle, selected by grant.
  - result valid; busy=1.
  - Next edge: go to IDLE.
- Latency and throughput:
  - done asserts WIDTH cycles after the sampling edge.
  - busy is high WIDTH+1 cycles.
  - Peak throughput: one operation per WIDTH+2 cycles.
- Handshake:
  - Requester holds req and operands stable until it sees its done.
  - It deasserts req before the edge following IDLE re-entry; req still high there is a new request.
  - Operands may change after the grant edge, since they are latched.
- Requests arriving during SHIFT/DONE wait; there is no starvation because of round-robin.
- Timing: the cell is combinational with gate delays (sel XOR 10 ns plus full-adder path). The clock period in simulation must exceed the total cell settling delay; bench uses 100 ns.

Decomposition:
- Shared include file `addsub_defs.vh` holds:
  - state encodings ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2.
  - OP_ADD=1'b0, OP_SUB=1'b1.
- Exactly one sub-module instance: `full_adder_substractor`, used unchanged as the datapath.
- Arbiter, counter, FSM and shift registers are inline.

Test Plan (WIDTH=8):
- Add: req0, op0=0, a0=8'h35, b0=8'h1A → done0 8 cycles after grant edge; result=8'h4F, carry_out=0, overflow=0, grant=0.
- Subtract with borrow: req1, op1=1, a1=8'h10, b1=8'h20 → done1; result=8'hF0, carry_out=0, overflow=0.
- Overflow: 8'h7F+8'h01 → result 8'h80, carry_out=0, overflow=1. Then 8'h80-8'h01 → 8'h7F, carry_out=1, overflow=1.
- Arbitration: req0 and req1 both high from reset, held → served 0,1,0,1; each done pulse is exactly one cycle, with ≥1 IDLE cycle between operations.
- Contention while busy: req1 asserted during requester 0's SHIFT → no grant change until IDLE, then grant=1 and done1 after WIDTH cycles; operands are not corrupted.
- Reset mid-op: rst_n low at count=3 → immediately busy=0, result=0, no done pulse. After release, req0 with 8'h01+8'h01 → 8'h02.
